// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/compare/shift ops, an early-terminating
// CLZ/CLO bit scan and a shift-add MULTU, with a valid/ready handshake on both sides.
// The result and flags are registered and held until the consumer takes them.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zeroFlag,
    output logic             negativeFlag,
    output logic             carryFlag,
    output logic             overFlowFlag
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_ADDU = 4'h1, OP_SUB  = 4'h2, OP_SUBU = 4'h3,
        OP_AND  = 4'h4, OP_OR   = 4'h5, OP_XOR  = 4'h6, OP_NOR  = 4'h7,
        OP_SLT  = 4'h8, OP_SLTU = 4'h9, OP_SLLV = 4'hA, OP_SRLV = 4'hB,
        OP_SRAV = 4'hC, OP_CLZ  = 4'hD, OP_CLO  = 4'hE, OP_MULTU = 4'hF
    } op_t;

    state_t               state_q, state_d;
    op_t                  op_q, op_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [SHW:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     result_hi_q, result_hi_d;
    logic                 zero_q, zero_d;
    logic                 neg_q, neg_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;

    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH:0]       diff_ext;
    logic [SHW-1:0]       amt;
    logic [WIDTH:0]       mul_sum;
    logic                 scan_done;
    logic                 scan_target;

    assign amt = b[SHW-1:0];

    // Single-cycle function of the live operands, used on the accept cycle
    always_comb begin
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        sum_ext  = {1'b0, a} + {1'b0, b};
        diff_ext = {1'b0, a} - {1'b0, b};
        case (op_t'(op))
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBU: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLLV: alu_res = a << amt;
            OP_SRLV: alu_res = a >> amt;
            OP_SRAV: alu_res = $unsigned($signed(a) >>> amt);
            default: ;
        endcase
    end

    // Handshake FSM, CLZ/CLO scan and shift-add multiply next-state logic
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        opa_d       = opa_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        mul_sum     = '0;
        scan_done   = 1'b0;
        scan_target = (op_q == OP_CLO);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d = op_t'(op);
                    if (op < OP_CLZ) begin
                        result_d    = alu_res;
                        result_hi_d = '0;
                        zero_d      = (alu_res == '0);
                        neg_d       = alu_res[WIDTH-1];
                        carry_d     = alu_c;
                        ovf_d       = alu_v;
                        state_d     = S_DONE;
                    end else begin
                        opa_d   = a;
                        prod_d  = {{WIDTH{1'b0}}, b};
                        cnt_d   = '0;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (op_q == OP_MULTU) begin
                    mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opa_q} : '0);
                    prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == (SHW+1)'(WIDTH - 1)) begin
                        result_d    = prod_d[WIDTH-1:0];
                        result_hi_d = prod_d[2*WIDTH-1:WIDTH];
                        zero_d      = (prod_d == '0);
                        neg_d       = prod_d[WIDTH-1];
                        carry_d     = 1'b0;
                        ovf_d       = 1'b0;
                        state_d     = S_DONE;
                    end
                end else begin
                    if (opa_q[WIDTH-1] == scan_target) begin
                        cnt_d = cnt_q + 1'b1;
                        opa_d = opa_q << 1;
                        scan_done = (cnt_d == (SHW+1)'(WIDTH));
                    end else begin
                        scan_done = 1'b1;
                    end
                    if (scan_done) begin
                        result_d          = '0;
                        result_d[SHW:0]   = cnt_d;
                        result_hi_d       = '0;
                        zero_d            = (cnt_d == '0);
                        neg_d             = result_d[WIDTH-1];
                        carry_d           = 1'b0;
                        ovf_d             = 1'b0;
                        state_d           = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ADD;
            opa_q       <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opa_q       <= opa_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign result       = result_q;
    assign result_hi    = result_hi_q;
    assign zeroFlag     = zero_q;
    assign negativeFlag = neg_q;
    assign carryFlag    = carry_q;
    assign overFlowFlag = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed vector table, randomized ops against a
// reference model, plus backpressure and mid-operation reset sequences.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        zeroFlag;
    logic        negativeFlag;
    logic        carryFlag;
    logic        overFlowFlag;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op_i),
        .a           (a_i),
        .b           (b_i),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_hi   (result_hi),
        .zeroFlag    (zeroFlag),
        .negativeFlag(negativeFlag),
        .carryFlag   (carryFlag),
        .overFlowFlag(overFlowFlag)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] hi;
        logic [3:0]  flg;   // {zero, negative, carry, overflow}
        int          lat;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {zeroFlag, negativeFlag, carryFlag, overFlowFlag};
    endfunction

    // Reference model from the arithmetic definitions of each op
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [31:0] hi,
                         output logic [3:0] flg, output int lat);
        longint          s;
        longint unsigned p;
        logic            c, v, z;
        int              n;
        int              amt;
        c = 1'b0; v = 1'b0; hi = '0; res = '0; lat = 1;
        amt = int'(b % 32);
        case (op)
            4'h0: begin s = longint'($signed(a)) + longint'($signed(b));
                        res = a + b; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'h1: begin p = longint'(a) + longint'(b); res = a + b; c = (p >= 64'h1_0000_0000); end
            4'h2: begin s = longint'($signed(a)) - longint'($signed(b));
                        res = a - b; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'h3: begin res = a - b; c = (a < b); end
            4'h4: res = a & b;
            4'h5: res = a | b;
            4'h6: res = a ^ b;
            4'h7: res = ~(a | b);
            4'h8: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h9: res = (a < b) ? 32'd1 : 32'd0;
            4'hA: res = a << amt;
            4'hB: res = a >> amt;
            4'hC: begin s = longint'($signed(a)) >>> amt; res = s[31:0]; end
            4'hD, 4'hE: begin
                n = 0;
                for (int i = 31; i >= 0; i--) begin
                    if (a[i] != (op == 4'hE)) break;
                    n++;
                end
                res = n;
                lat = ((n + 1 < 32) ? n + 1 : 32) + 1;
            end
            default: begin
                p = longint'(a) * longint'(b);
                res = p[31:0]; hi = p[63:32]; lat = 33;
            end
        endcase
        z = (op == 4'hF) ? ({hi, res} == 64'd0) : (res == 32'd0);
        flg = {z, res[31], c, v};
    endtask

    // Issue one op and wait (bounded) until out_valid; returns in DONE with outputs sampled
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [31:0] hi,
                          output logic [3:0] flg, output int lat, output bit ok);
        int waitc = 0;
        ok = 1'b0; res = '0; hi = '0; flg = '0; lat = 0;
        @(negedge clk);
        while (!in_ready && waitc < 100) begin @(negedge clk); waitc++; end
        if (!in_ready) begin chk("in_ready_timeout", 64'(in_ready), 64'd1); return; end
        in_valid = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk); #1;
        in_valid = 1'b0; op_i = 4'($urandom); a_i = $urandom; b_i = $urandom;
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 100);
        if (!out_valid) begin chk("out_valid_timeout", 64'(out_valid), 64'd1); return; end
        res = result; hi = result_hi; flg = flags_now(); ok = 1'b1;
    endtask

    // Consume the result and confirm return to IDLE the next cycle
    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_idle_out_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] r, h, er, eh, ra, rb;
        logic [3:0]  f, ef, rop;
        logic [31:0] hold_r;
        logic [3:0]  hold_f;
        int          lat, elat;
        bit          ok;

        tbl[0]  = '{4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 4'b0101, 1};
        tbl[1]  = '{4'h3, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h0, 4'b0110, 1};
        tbl[2]  = '{4'h8, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h0, 4'b0000, 1};
        tbl[3]  = '{4'h9, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h0, 4'b1000, 1};
        tbl[4]  = '{4'hD, 32'h00001000, 32'h00000000, 32'd19,        32'h0, 4'b0000, 21};
        tbl[5]  = '{4'hD, 32'h80000000, 32'h00000000, 32'd0,         32'h0, 4'b1000, 2};
        tbl[6]  = '{4'hE, 32'hFFFFFFFF, 32'h00000000, 32'd32,        32'h0, 4'b0000, 33};
        tbl[7]  = '{4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 4'b0000, 33};
        tbl[8]  = '{4'hC, 32'h80000000, 32'h00000024, 32'hF8000000, 32'h0, 4'b0100, 1};
        tbl[9]  = '{4'hD, 32'h00000000, 32'h00000000, 32'd32,        32'h0, 4'b0000, 33};
        tbl[10] = '{4'hE, 32'h00000000, 32'h00000000, 32'd0,         32'h0, 4'b1000, 2};
        tbl[11] = '{4'h1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 4'b1010, 1};
        tbl[12] = '{4'h2, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 4'b0001, 1};
        tbl[13] = '{4'hF, 32'h00000000, 32'h00012345, 32'h00000000, 32'h0, 4'b1000, 33};
        tbl[14] = '{4'h7, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 4'b0100, 1};
        tbl[15] = '{4'hA, 32'h00000001, 32'h0000003F, 32'h80000000, 32'h0, 4'b0100, 1};
        tbl[16] = '{4'hE, 32'hF0000000, 32'h00000000, 32'd4,         32'h0, 4'b0000, 6};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_i = '0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_result_hi", 64'(result_hi), 64'd0);
        chk("rst_flags", 64'(flags_now()), 64'd0);

        // Directed vectors
        for (int i = 0; i < 17; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, h, f, lat, ok);
            if (ok) begin
                chk($sformatf("vec%0d_result", i), 64'(r), 64'(tbl[i].res));
                chk($sformatf("vec%0d_hi", i), 64'(h), 64'(tbl[i].hi));
                chk($sformatf("vec%0d_flags", i), 64'(f), 64'(tbl[i].flg));
                chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
                chk($sformatf("vec%0d_in_ready_busy", i), 64'(in_ready), 64'd0);
                release_out($sformatf("vec%0d", i));
            end
        end

        // Randomized ops against the model
        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 3))
                0: ra = ra >> $urandom_range(0, 31);
                1: ra = ~(ra >> $urandom_range(0, 31));
                2: rb = rb & 32'h0000FFFF;
                default: ;
            endcase
            model(rop, ra, rb, er, eh, ef, elat);
            run_op(rop, ra, rb, r, h, f, lat, ok);
            if (ok) begin
                chk($sformatf("rnd%0d_op%0h_result", i, rop), 64'(r), 64'(er));
                chk($sformatf("rnd%0d_op%0h_hi", i, rop), 64'(h), 64'(eh));
                chk($sformatf("rnd%0d_op%0h_flags", i, rop), 64'(f), 64'(ef));
                chk($sformatf("rnd%0d_op%0h_latency", i, rop), 64'(lat), 64'(elat));
                release_out($sformatf("rnd%0d", i));
            end
        end

        // Backpressure: result held while out_ready=0 and inputs churn
        run_op(4'h2, 32'd3, 32'd10, r, h, f, lat, ok);
        if (ok) begin
            hold_r = r; hold_f = f;
            chk("bp_result_initial", 64'(r), 64'hFFFFFFF9);
            chk("bp_flags_initial", 64'(f), 64'b0100);
            for (int k = 0; k < 5; k++) begin
                in_valid = 1'($urandom); a_i = $urandom; b_i = $urandom; op_i = 4'($urandom);
                @(negedge clk);
                chk($sformatf("bp%0d_result", k), 64'(result), 64'(hold_r));
                chk($sformatf("bp%0d_flags", k), 64'(flags_now()), 64'(hold_f));
                chk($sformatf("bp%0d_out_valid", k), 64'(out_valid), 64'd1);
                chk($sformatf("bp%0d_in_ready", k), 64'(in_ready), 64'd0);
            end
            in_valid = 1'b0;
            release_out("bp");
            chk("bp_idle_result_kept", 64'(result), 64'(hold_r));
        end

        // Reset during MULTU EXEC cycle 10 aborts, then a fresh ADD
        @(negedge clk);
        in_valid = 1'b1; op_i = 4'hF; a_i = 32'h12345678; b_i = 32'h9ABCDEF1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mrst_busy_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_busy_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        chk("mrst_result", 64'(result), 64'd0);
        chk("mrst_result_hi", 64'(result_hi), 64'd0);
        chk("mrst_flags", 64'(flags_now()), 64'd0);
        run_op(4'h0, 32'd2, 32'd3, r, h, f, lat, ok);
        if (ok) begin
            chk("post_rst_add_result", 64'(r), 64'd5);
            chk("post_rst_add_latency", 64'(lat), 64'd1);
            chk("post_rst_add_flags", 64'(f), 64'd0);
            release_out("post_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
